// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 write-only register peripheral. A 16-bit frame carries a write flag,
// a 7-bit address and 8 data bits. Valid writes update one of five 8-bit
// configuration registers when chip select deasserts.
module spi_reg_peripheral #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  typedef enum logic [1:0] {StIdle, StRecv, StCommit} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_prev_q, ncs_prev_q;
  // Fills with ones after reset. The top bit marks the point where both ncs_s and
  // ncs_prev come from the real pin rather than from reset values.
  logic [SYNC_STAGES:0]   flush_q;

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_rise, ncs_fall;

  state_e      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        commit;
  logic        wr_en;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;
  // A low ncs inherited across reset shows up as a fake falling edge; mask it.
  assign ncs_fall  = ~ncs_s & ncs_prev_q & flush_q[SYNC_STAGES];

  // Input synchronisers and edge-detect history flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
      flush_q     <= '0;
    end else begin
      sclk_sync_q[0] <= sclk;
      copi_sync_q[0] <= copi;
      ncs_sync_q[0]  <= ncs;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sclk_sync_q[i] <= sclk_sync_q[i-1];
        copi_sync_q[i] <= copi_sync_q[i-1];
        ncs_sync_q[i]  <= ncs_sync_q[i-1];
      end
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
      flush_q     <= {flush_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Frame FSM, shift register and bit counter state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; ncs rising takes priority over a coincident sclk edge.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ncs_fall) begin
          state_d = StRecv;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      StRecv: begin
        if (ncs_rise) begin
          state_d = StCommit;
        end else if (sclk_rise && !ncs_s) begin
          shift_d = {shift_q[14:0], copi_s};
          // 17 marks an overlong frame and is held there.
          if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
        end
      end
      StCommit: begin
        state_d = StIdle;
        commit  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign wr_en = commit && (cnt_q == 5'd16) && shift_q[15] && (shift_q[14:8] <= MAX_ADDR);

  // Configuration registers; only a complete, in-range write frame touches them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
    end else if (wr_en) begin
      case (shift_q[14:8])
        7'h00:   en_reg_out_7_0  <= shift_q[7:0];
        7'h01:   en_reg_out_15_8 <= shift_q[7:0];
        7'h02:   en_reg_pwm_7_0  <= shift_q[7:0];
        7'h03:   en_reg_pwm_15_8 <= shift_q[7:0];
        7'h04:   pwm_duty_cycle  <= shift_q[7:0];
        default: ;
      endcase
    end
  end

endmodule
